// File: rtl/lfsr_seq_ctrl.sv
// Start/done sequencing controller around a 4-bit maximal-length LFSR (x^4+x+1).
// Loads a seed, performs a programmed number of shifts, and supports pause and abort.
module lfsr_seq_ctrl #(
  parameter int unsigned STEP_W   = 8,
  parameter logic [3:0]  DEF_SEED = 4'b0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        seed,
  input  logic [STEP_W-1:0] steps,
  input  logic              pause,
  input  logic              abort,
  output logic [3:0]        q,
  output logic              q_valid,
  output logic              wrap,
  output logic              busy,
  output logic              done,
  output logic              seed_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [STEP_W-1:0] StepOne = {{(STEP_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [3:0]        seed_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] remaining_q;
  logic [3:0]        loaded_q;
  logic [3:0]        q_shift;

  assign q_shift = {q[1] ^ q[0], q[3], q[2], q[1]};

  assign busy = (state_q == StLoad) || (state_q == StRun);
  assign done = (state_q == StDone);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      seed_q      <= '0;
      steps_q     <= '0;
      remaining_q <= '0;
      loaded_q    <= DEF_SEED;
      q           <= DEF_SEED;
      q_valid     <= 1'b0;
      wrap        <= 1'b0;
      seed_err    <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      wrap    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            seed_q   <= seed;
            steps_q  <= steps;
            seed_err <= 1'b0;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            // An all-zero seed would lock the LFSR, so substitute the default.
            if (seed_q == 4'b0000) begin
              q        <= DEF_SEED;
              loaded_q <= DEF_SEED;
              seed_err <= 1'b1;
            end else begin
              q        <= seed_q;
              loaded_q <= seed_q;
            end
            remaining_q <= steps_q;
            state_q     <= (steps_q == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (!pause) begin
            q           <= q_shift;
            remaining_q <= remaining_q - StepOne;
            q_valid     <= 1'b1;
            wrap        <= (q_shift == loaded_q);
            if (remaining_q == StepOne) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-level behavioural model.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic [7:0] steps;
  logic       pause;
  logic       abort;
  logic [3:0] q;
  logic       q_valid;
  logic       wrap;
  logic       busy;
  logic       done;
  logic       seed_err;

  int total = 0;
  int bad   = 0;

  // Observed output bundle: {q, q_valid, wrap, busy, done, seed_err}
  logic [8:0] obs;
  assign obs = {q, q_valid, wrap, busy, done, seed_err};

  logic [3:0] period_tbl [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110,
                                  4'b1011, 4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111,
                                  4'b0111, 4'b0011, 4'b0001};

  lfsr_seq_ctrl #(
    .STEP_W  (8),
    .DEF_SEED(4'b0001)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seed    (seed),
    .steps   (steps),
    .pause   (pause),
    .abort   (abort),
    .q       (q),
    .q_valid (q_valid),
    .wrap    (wrap),
    .busy    (busy),
    .done    (done),
    .seed_err(seed_err)
  );

  always #5 clk = ~clk;

  // Reference shift: new MSB is q1 xor q0, the rest move down one place.
  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    int unsigned x;
    x = int'(v);
    return 4'((x >> 1) + (((x ^ (x >> 1)) & 1) * 8));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst = 1'b0; start = 1'b0; seed = '0; steps = '0; pause = 1'b0; abort = 1'b0;
    #12;
    exp = {4'b0001, 5'b00000};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL reset_state: got %b want %b", obs, exp);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL reset_idle: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_full_period(input string name);
    logic [8:0] exp;
    start = 1'b1; seed = 4'b0001; steps = 8'd15;
    cyc();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || q_valid !== 1'b0) begin
      bad++; $display("FAIL %s_load: got %b", name, obs);
    end
    cyc();
    exp = {4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL %s_seeded: got %b want %b", name, obs, exp);
    end
    for (int i = 0; i < 15; i++) begin
      cyc();
      exp = {period_tbl[i], 1'b1, (i == 14), (i != 14), (i == 14), 1'b0};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL %s_shift%0d: got %b want %b", name, i + 1, obs, exp);
      end
    end
    cyc();
    exp = {4'b0001, 5'b00000};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL %s_idle: got %b want %b", name, obs, exp);
    end
  endtask

  task automatic test_zero_seed();
    logic [8:0] exp;
    start = 1'b1; seed = 4'b0000; steps = 8'd2;
    cyc();
    start = 1'b0;
    cyc();
    exp = {4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL zero_seed_load: got %b want %b", obs, exp);
    end
    cyc();
    exp = {4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL zero_seed_shift1: got %b want %b", obs, exp);
    end
    cyc();
    exp = {4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL zero_seed_done: got %b want %b", obs, exp);
    end
    cyc();
    total++;
    if (seed_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_seed_sticky: got %b want seed_err=1 busy=0", obs);
    end
    start = 1'b1; seed = 4'b0101; steps = 8'd0;
    cyc();
    start = 1'b0;
    total++;
    if (seed_err !== 1'b0) begin
      bad++; $display("FAIL zero_seed_clear: got seed_err=%b want 0", seed_err);
    end
    cyc();
    exp = {4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL zero_seed_next: got %b want %b", obs, exp);
    end
    cyc();
  endtask

  task automatic test_pause();
    logic [8:0] exp;
    start = 1'b1; seed = 4'b0001; steps = 8'd4;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    exp = {4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL pause_pre: got %b want %b", obs, exp);
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp = {4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL pause_hold%0d: got %b want %b", i, obs, exp);
      end
    end
    pause = 1'b0;
    cyc();
    exp = {4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL pause_shift3: got %b want %b", obs, exp);
    end
    cyc();
    exp = {4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL pause_done: got %b want %b", obs, exp);
    end
    cyc();
  endtask

  task automatic test_abort();
    logic [8:0] exp;
    start = 1'b1; seed = 4'b0001; steps = 8'd10;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    start = 1'b1; seed = 4'b0111; steps = 8'd0;
    cyc();
    start = 1'b0;
    cyc();
    exp = {4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL abort_pre: got %b want %b", obs, exp);
    end
    abort = 1'b1; pause = 1'b1;
    cyc();
    abort = 1'b0; pause = 1'b0;
    exp = {4'b0010, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL abort_idle%0d: got %b want %b", i, obs, exp);
      end
      cyc();
    end
  endtask

  task automatic test_steps_zero();
    logic [8:0] exp;
    start = 1'b1; seed = 4'b1011; steps = 8'd0;
    cyc();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL steps0_load: got %b", obs);
    end
    cyc();
    exp = {4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL steps0_done: got %b want %b", obs, exp);
    end
    cyc();
    exp = {4'b1011, 5'b00000};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL steps0_idle: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] exp;
    start = 1'b1; seed = 4'b0000; steps = 8'd20;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    exp = {4'b0001, 5'b00000};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL reset_mid_run: got %b want %b", obs, exp);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL reset_release: got %b want %b", obs, exp);
    end
    test_full_period("after_reset");
  endtask

  task automatic test_random();
    logic [8:0] exp;
    logic [3:0] sd, loaded, eq;
    logic       err, p;
    int         st, left, guard;
    for (int t = 0; t < 20; t++) begin
      sd     = 4'($urandom_range(0, 15));
      st     = int'($urandom_range(0, 20));
      loaded = (sd == 4'b0000) ? 4'b0001 : sd;
      err    = (sd == 4'b0000);
      start = 1'b1; seed = sd; steps = 8'(st);
      cyc();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || q_valid !== 1'b0 || seed_err !== 1'b0) begin
        bad++; $display("FAIL rand%0d_accept: got %b", t, obs);
      end
      cyc();
      exp = {loaded, 1'b0, 1'b0, (st != 0), (st == 0), err};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL rand%0d_load: got %b want %b", t, obs, exp);
      end
      eq = loaded; left = st; guard = 0;
      while (left > 0 && guard < 200) begin
        p = ($urandom_range(0, 3) == 0);
        pause = p;
        cyc();
        guard++;
        if (!p) begin
          eq = lfsr_next(eq);
          left--;
        end
        exp = {eq, !p, (!p && eq == loaded), (left != 0), (left == 0), err};
        total++;
        if (obs !== exp) begin
          bad++; $display("FAIL rand%0d_cycle%0d: got %b want %b", t, guard, obs, exp);
        end
      end
      pause = 1'b0;
      total++;
      if (left != 0) begin
        bad++; $display("FAIL rand%0d_budget: got left=%0d want 0", t, left);
      end
      cyc();
      exp = {eq, 1'b0, 1'b0, 1'b0, 1'b0, err};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL rand%0d_idle: got %b want %b", t, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_period("full_period");
    test_zero_seed();
    test_pause();
    test_abort();
    test_steps_zero();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencing controller for the 4-bit maximal-length shift-register datapath (x^4+x+1, period 15). It loads a seed, runs the register for a programmed number of shifts, supports pause and abort, and reports each new value and completion through single-cycle pulses. It sits between a test or control master and the pseudo-random source, and replaces free-running operation with a start/done transaction.

## Interface
- STEP_W, 8, width of the shift-count input and the internal remaining-count register
- DEF_SEED, 4'b0001, reset value of q; also substituted for an all-zero seed

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a transaction; sampled only in IDLE
- seed  in  4  initial register value; captured with start
- steps  in  STEP_W  number of shifts to perform; captured with start
- pause  in  1  freezes shifting in RUN while high
- abort  in  1  terminates a LOAD/RUN transaction
- q  out  4  register value {q3,q2,q1,q0}
- q_valid  out  1  one-cycle pulse, high in the cycle after each shift
- wrap  out  1  one-cycle pulse, high when a shift returns q to the captured seed
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse, high in DONE
- seed_err  out  1  sticky; set when an all-zero seed is loaded, cleared by the next accepted start

## Operation
- Shift rule, one step: q_next = {q1^q0, q3, q2, q1}. The register shifts only in RUN with pause=0 and abort=0.
- The FSM has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 moves to LOAD and captures seed and steps into internal registers.
  - q holds its value.
- LOAD:
  - q is set to the captured seed, or to DEF_SEED if the seed is 4'b0000; in that case seed_err is set to 1.
  - remaining is set to steps.
  - Next state is DONE if steps=0, otherwise RUN.
- RUN:
  - Each cycle with pause=0 and abort=0: shift, remaining decrements, q_valid pulses.
  - wrap pulses if the new q equals the loaded value.
  - The shift that brings remaining to 0 moves the FSM to DONE.
  - With pause=1: q, remaining and state hold, and no pulses are issued.
- DONE: done=1 for one cycle, then the FSM returns to IDLE unconditionally.
- abort:
  - In LOAD or RUN, abort has priority over pause and shifting.
  - The next state is IDLE, q holds, and done is not pulsed.
  - abort in IDLE or DONE is ignored.
- start outside IDLE is ignored; no queuing.
- A start in the same cycle as the DONE→IDLE return is ignored; start is accepted only while the state is IDLE.
- Reset, asynchronous, also during a transaction:
  - state=IDLE, q=DEF_SEED, remaining=0.
  - busy=0, done=0, q_valid=0, wrap=0, seed_err=0.
  - The captured seed and steps are cleared.

## Timing
- Accepted start at edge E0 → LOAD during cycle 1, q=seed after edge E1.
- With steps=N≥1 and no pause, the shifts occur at edges E2…E(N+1), and q_valid is high in each of the following cycles.
- done is high in the cycle after E(N+1), which is the same cycle as the last q_valid. The FSM is back in IDLE after E(N+2).
- Each paused cycle adds exactly one cycle of latency.
- steps=0: done is high in the cycle after E1, and no q_valid is issued.
- q, q_valid, wrap, seed_err and remaining are registered outputs. busy and done are decoded from the state register, so there is no combinational path from any input to an output.
- remaining is STEP_W bits wide. It never underflows, because the transition to DONE occurs at the decrement to 0.

## Test plan
- Full period: seed=4'b0001, steps=15 → q steps through 1000, 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001. Expect 15 q_valid pulses, wrap only on the 15th, done in that same cycle, and busy low afterwards.
- Zero seed: seed=4'b0000, steps=2 → q=0001 after LOAD, seed_err=1, q=1000 then 0100, done. The next start with seed=4'b0101 clears seed_err.
- Pause: seed=4'b0001, steps=4, pause high for 3 cycles after the 2nd shift → q holds 0100 with no q_valid during the pause. done arrives 3 cycles later than the unpaused case, and the final q is 1001.
- Abort: steps=10, abort asserted after the 3rd shift (q=0010) → next state IDLE, q stays 0010, done never pulses, busy falls. start pulses during RUN are ignored.
- steps=0 with seed=4'b1011 → q=1011, no q_valid, done one cycle after LOAD.
- Reset mid-RUN (rst low asynchronously between edges) → q=0001 and all outputs 0 immediately. After rst is released, the block is in IDLE and a new transaction behaves exactly as in the full-period test.
